// File: rtl/dnn_pkg.sv
// dnn_pkg: geometry helpers shared by DNN and its sample feeder.
// Both sides derive block length from the same functions.
package dnn_pkg;

  localparam int ETAPOS_W_DEF = 4;

  function automatic int chunks(input int n0, input int z0, input int fo0);
    return (n0 * fo0) / z0;
  endfunction

  function automatic int cpc(input int n0, input int z0, input int fo0);
    return chunks(n0, z0, fo0) + 2;
  endfunction

  function automatic int y_clk(input int nout, input int y_w);
    return nout / y_w;
  endfunction

  function automatic int bits_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dnn_sample_feeder_sample_bank.sv
// sample_bank: one sample worth of chunks plus its label and etapos.
// Chunks are read back by block count; counts past the data read 0.
module sample_bank
  import dnn_pkg::*;
#(
  parameter int A_W      = 128,
  parameter int CHUNKS   = 4,
  parameter int WI_W     = 2,
  parameter int CNT_W    = 3,
  parameter int LBL_W    = 2,
  parameter int ETAPOS_W = ETAPOS_W_DEF
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [WI_W-1:0]     i_wi,
  input  logic [A_W-1:0]      i_data,
  input  logic [LBL_W-1:0]    i_label,
  input  logic [ETAPOS_W-1:0] i_etapos,
  input  logic [CNT_W-1:0]    i_cnt,
  output logic [A_W-1:0]      o_chunk,
  output logic [LBL_W-1:0]    o_label,
  output logic [ETAPOS_W-1:0] o_etapos
);

  logic [A_W-1:0]      r_mem [CHUNKS];
  logic [LBL_W-1:0]    r_label;
  logic [ETAPOS_W-1:0] r_etapos;

  // Capture a chunk; per-sample fields come with chunk 0 only.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wi] <= i_data;
      if (i_wi == '0) begin
        r_label  <= i_label;
        r_etapos <= i_etapos;
      end
    end
  end

  // Chunk selected by the block counter, zero on the two tail counts.
  always_comb begin
    o_chunk = '0;
    if (i_cnt < CNT_W'(CHUNKS)) begin
      o_chunk = r_mem[i_cnt[WI_W-1:0]];
    end
  end

  assign o_label  = r_label;
  assign o_etapos = r_etapos;

endmodule

// File: rtl/dnn_sample_feeder.sv
// dnn_sample_feeder: double-buffered sample loader replaying a sample
// per DNN block, in lockstep with DNN's block counter.
module dnn_sample_feeder
  import dnn_pkg::*;
#(
  parameter int width_in = 8,
  parameter int n0       = 64,
  parameter int z0       = 32,
  parameter int fo0      = 2,
  parameter int nout     = 4,
  parameter int y_w      = 1,
  parameter int etapos_w = ETAPOS_W_DEF,
  parameter logic [etapos_w-1:0] etapos_idle = '1,
  localparam int A_W     = width_in * z0 / fo0,
  localparam int LBL_W   = bits_of(nout)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [A_W-1:0]      s_data,
  input  logic [LBL_W-1:0]    s_label,
  input  logic [etapos_w-1:0] s_etapos,
  output logic [A_W-1:0]      a_in,
  output logic [y_w-1:0]      y_in,
  output logic [etapos_w-1:0] etapos_in,
  output logic                sample_active,
  output logic [31:0]         samples_fed
);

  localparam int CHUNKS = chunks(n0, z0, fo0);
  localparam int CPC    = cpc(n0, z0, fo0);
  localparam int Y_CLK  = y_clk(nout, y_w);
  localparam int CNT_W  = bits_of(CPC);
  localparam int WI_W   = bits_of(CHUNKS);
  localparam int OH_W   = (CPC * y_w > nout) ? CPC * y_w : nout;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPC - 1);
  localparam logic [WI_W-1:0]  WI_LAST  = WI_W'(CHUNKS - 1);

  logic [CNT_W-1:0]    r_cnt;
  logic [WI_W-1:0]     r_wi;
  logic                r_wr_bank;
  logic                r_rd_bank;
  logic                r_active;
  logic [1:0]          r_full;
  logic [31:0]         r_samples_fed;

  logic                w_bnd;
  logic                w_acc;
  logic                w_last;
  logic                w_next;
  logic [1:0]          w_we;
  logic [A_W-1:0]      w_chunk  [2];
  logic [LBL_W-1:0]    w_label  [2];
  logic [etapos_w-1:0] w_etapos [2];
  logic [OH_W-1:0]     w_oh;

  assign s_ready = !r_full[r_wr_bank];
  assign w_acc   = s_valid && s_ready;
  assign w_last  = w_acc && (r_wi == WI_LAST);
  assign w_bnd   = (r_cnt == CNT_LAST);
  // An active block hands over to the other bank; a bubble retries
  // the same bank.
  assign w_next  = r_rd_bank ^ r_active;
  assign w_we    = {w_acc && r_wr_bank, w_acc && !r_wr_bank};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sample_bank #(
      .A_W      (A_W),
      .CHUNKS   (CHUNKS),
      .WI_W     (WI_W),
      .CNT_W    (CNT_W),
      .LBL_W    (LBL_W),
      .ETAPOS_W (etapos_w)
    ) u_bank (
      .clk      (clk),
      .i_we     (w_we[b]),
      .i_wi     (r_wi),
      .i_data   (s_data),
      .i_label  (s_label),
      .i_etapos (s_etapos),
      .i_cnt    (r_cnt),
      .o_chunk  (w_chunk[b]),
      .o_label  (w_label[b]),
      .o_etapos (w_etapos[b])
    );
  end

  // Block counter, mirrors DNN's cycle index from a shared reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_bnd) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Write side: chunk index and bank pointer advance on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wi      <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_last) begin
      r_wi      <= '0;
      r_wr_bank <= ~r_wr_bank;
    end else if (w_acc) begin
      r_wi      <= r_wi + 1'b1;
    end
  end

  // Full flags: set by the writer, released when a replay completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 2'b00;
    end else begin
      if (w_last) begin
        r_full[r_wr_bank] <= 1'b1;
      end
      if (w_bnd && r_active) begin
        r_full[r_rd_bank] <= 1'b0;
      end
    end
  end

  // Read side: at each boundary decide active vs bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_bank     <= 1'b0;
      r_active      <= 1'b0;
      r_samples_fed <= '0;
    end else if (w_bnd) begin
      r_rd_bank <= w_next;
      r_active  <= r_full[w_next];
      if (r_full[w_next]) begin
        r_samples_fed <= r_samples_fed + 32'd1;
      end
    end
  end

  // One-hot of the replayed label; out-of-range labels give zero.
  always_comb begin
    w_oh = '0;
    if (int'(w_label[r_rd_bank]) < nout) begin
      w_oh[w_label[r_rd_bank]] = 1'b1;
    end
  end

  // Replay outputs, idle values during a bubble.
  always_comb begin
    a_in      = '0;
    y_in      = '0;
    etapos_in = etapos_idle;
    if (r_active) begin
      a_in      = w_chunk[r_rd_bank];
      etapos_in = w_etapos[r_rd_bank];
      if (int'(r_cnt) < Y_CLK) begin
        y_in = w_oh[int'(r_cnt) * y_w +: y_w];
      end
    end
  end

  assign sample_active = r_active;
  assign samples_fed   = r_samples_fed;

endmodule

// File: tb/tb_dnn_sample_feeder.sv
// tb_dnn_sample_feeder: directed checks of replay, backpressure,
// bubbles, boundary race, label range and mid-load reset.
module tb_dnn_sample_feeder;

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         s_valid  = 1'b0;
  logic [127:0] s_data   = '0;
  logic [1:0]   s_label  = '0;
  logic [3:0]   s_etapos = '0;

  logic         s_ready, s_ready3;
  logic [127:0] a_in, a_in3;
  logic         y_in, y_in3;
  logic [3:0]   etapos_in, etapos_in3;
  logic         sample_active, sample_active3;
  logic [31:0]  samples_fed, samples_fed3;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dnn_sample_feeder dut (
    .clk           (clk),
    .reset         (reset),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_label       (s_label),
    .s_etapos      (s_etapos),
    .a_in          (a_in),
    .y_in          (y_in),
    .etapos_in     (etapos_in),
    .sample_active (sample_active),
    .samples_fed   (samples_fed)
  );

  dnn_sample_feeder #(.nout(3)) dut3 (
    .clk           (clk),
    .reset         (reset),
    .s_valid       (s_valid),
    .s_ready       (s_ready3),
    .s_data        (s_data),
    .s_label       (s_label),
    .s_etapos      (s_etapos),
    .a_in          (a_in3),
    .y_in          (y_in3),
    .etapos_in     (etapos_in3),
    .sample_active (sample_active3),
    .samples_fed   (samples_fed3)
  );

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_bubble(input string tag);
    check({tag, "_act"}, 128'(sample_active), 128'd0);
    check({tag, "_a"}, a_in, 128'd0);
    check({tag, "_y"}, 128'(y_in), 128'd0);
    check({tag, "_eta"}, 128'(etapos_in), 128'hF);
  endtask

  task automatic put_chunk(input logic [7:0] b, input logic [1:0] lbl,
                           input logic [3:0] eta);
    int n = 0;
    s_valid  = 1'b1;
    s_data   = rep(b);
    s_label  = lbl;
    s_etapos = eta;
    while (s_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      $error("FAIL ready_timeout: observed s_ready=%b expected 1", s_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Later chunks carry garbage label/etapos to prove chunk-0 sampling.
  task automatic feed(input logic [7:0] base, input logic [1:0] lbl,
                      input logic [3:0] eta);
    for (int i = 0; i < 4; i++) begin
      put_chunk(base + 8'(i), (i == 0) ? lbl : ~lbl, (i == 0) ? eta : ~eta);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk_bubble("rst");
    check("rst_ready", 128'(s_ready), 128'd1);
    check("rst_fed", 128'(samples_fed), 128'd0);
    check("rst_ready3", 128'(s_ready3), 128'd1);
    check("rst_fed3", 128'(samples_fed3), 128'd0);
    reset = 1'b0;

    for (int k = 0; k < 12; k++) begin
      chk_bubble("starve");
      @(negedge clk);
    end
    check("starve_fed", 128'(samples_fed), 128'd0);

    feed(8'h01, 2'd2, 4'd3);
    s_valid = 1'b0;
    check("basic_pre_act", 128'(sample_active), 128'd0);
    repeat (2) @(negedge clk);
    check("basic_fed", 128'(samples_fed), 128'd1);
    for (int k = 0; k < 6; k++) begin
      check("basic_act", 128'(sample_active), 128'd1);
      check("basic_a", a_in, (k < 4) ? rep(8'(k + 1)) : 128'd0);
      check("basic_y", 128'(y_in), (k == 2) ? 128'd1 : 128'd0);
      check("basic_eta", 128'(etapos_in), 128'd3);
      @(negedge clk);
    end
    chk_bubble("basic_after");
    check("basic_fed_after", 128'(samples_fed), 128'd1);

    feed(8'h10, 2'd3, 4'd5);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      check("oor_a", a_in, (k < 4) ? rep(8'h10 + 8'(k)) : 128'd0);
      check("oor_y4", 128'(y_in), (k == 3) ? 128'd1 : 128'd0);
      check("oor_y3", 128'(y_in3), 128'd0);
      check("oor_act3", 128'(sample_active3), 128'd1);
      check("oor_eta", 128'(etapos_in), 128'd5);
      @(negedge clk);
    end
    check("oor_fed", 128'(samples_fed), 128'd2);

    repeat (2) @(negedge clk);
    feed(8'h30, 2'd0, 4'd9);
    s_valid = 1'b0;
    chk_bubble("race_bubble");
    repeat (6) @(negedge clk);
    check("race_act", 128'(sample_active), 128'd1);
    check("race_a0", a_in, rep(8'h30));
    check("race_y0", 128'(y_in), 128'd1);
    check("race_eta", 128'(etapos_in), 128'd9);
    check("race_fed", 128'(samples_fed), 128'd3);
    @(negedge clk);
    check("race_a1", a_in, rep(8'h31));
    check("race_y1", 128'(y_in), 128'd0);

    put_chunk(8'hAA, 2'd1, 4'd7);
    put_chunk(8'hAB, 2'd1, 4'd7);
    s_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_bubble("mid_rst");
    check("mid_rst_fed", 128'(samples_fed), 128'd0);
    check("mid_rst_ready", 128'(s_ready), 128'd1);
    @(negedge clk);
    reset = 1'b0;
    feed(8'h20, 2'd1, 4'd7);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_fed", 128'(samples_fed), 128'd1);
    for (int k = 0; k < 6; k++) begin
      check("mid_a", a_in, (k < 4) ? rep(8'h20 + 8'(k)) : 128'd0);
      check("mid_y", 128'(y_in), (k == 1) ? 128'd1 : 128'd0);
      check("mid_eta", 128'(etapos_in), 128'd7);
      @(negedge clk);
    end

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    feed(8'h40, 2'd0, 4'd1);
    feed(8'h50, 2'd1, 4'd2);
    check("b2b_stall", 128'(s_ready), 128'd0);
    check("b2b_act1", 128'(sample_active), 128'd1);
    check("b2b_fed1", 128'(samples_fed), 128'd1);
    feed(8'h60, 2'd2, 4'd3);
    s_valid = 1'b0;
    check("b2b_act2", 128'(sample_active), 128'd1);
    check("b2b_fed2", 128'(samples_fed), 128'd2);
    repeat (2) @(negedge clk);
    check("b2b_act3", 128'(sample_active), 128'd1);
    check("b2b_fed3", 128'(samples_fed), 128'd3);
    check("b2b_a3", a_in, rep(8'h60));
    check("b2b_eta3", 128'(etapos_in), 128'd3);
    repeat (6) @(negedge clk);
    chk_bubble("b2b_end");
    check("b2b_fed_end", 128'(samples_fed), 128'd3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
